// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback path.
package regfile_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // Writeback requester index assignment
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LSU = 2'd1,
    WB_CSR = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: per-source valid/ready handshake with packed addr/data.
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int N  = 3,
  parameter int XW = XLEN,
  parameter int AW = REG_ADDR_W
);

  logic [N-1:0]    src_valid;
  logic [N-1:0]    src_ready;
  logic [N*AW-1:0] src_addr;
  logic [N*XW-1:0] src_data;

  modport master (output src_valid, output src_addr, output src_data, input src_ready);
  modport slave  (input src_valid, input src_addr, input src_data, output src_ready);

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// pointer moves past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  input  logic          clear,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;

  // Cyclic priority search starting at the pointer
  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int off = 0; off < N; off++) begin
      idx = IW'((int'(ptr) + off) % N);
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

  // Pointer update: one past the winner on a taken grant, zero on clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among writeback sources, registers the
// winning write, and keeps a per-register pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int NUM_SRC    = 3,
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  localparam int IDX_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  regfile_wb_arbiter_if.slave           wb,
  output logic                          rf_we,
  output logic [REG_ADDR_W-1:0]         rf_wr_addr,
  output logic [XLEN-1:0]               rf_wr_data,
  input  logic                          issue_valid,
  input  logic [REG_ADDR_W-1:0]         issue_addr,
  output logic [regfile_pkg::NUM_REGS-1:0] busy,
  output logic                          issue_err
);

  import regfile_pkg::*;

  logic [NUM_SRC-1:0]    req;
  logic [NUM_SRC-1:0]    gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  xfer;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [XLEN-1:0]       sel_data;
  logic                  issue_hit;
  logic                  clr_same;
  logic [NUM_REGS-1:0]   busy_nxt;

  // Nothing is granted while flushing, and ready is held low in reset
  assign req          = wb.src_valid & {NUM_SRC{~flush}};
  assign wb.src_ready = rst ? gnt : '0;
  assign xfer         = |(wb.src_valid & wb.src_ready);

  rr_arbiter #(.N(NUM_SRC)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (xfer),
    .clear   (flush),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Mux out the winning source's destination and data
  always_comb begin
    sel_addr = wb.src_addr[gnt_idx*REG_ADDR_W +: REG_ADDR_W];
    sel_data = wb.src_data[gnt_idx*XLEN +: XLEN];
  end

  // Registered write port; x0 writes are accepted but never assert we
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we      <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else if (flush) begin
      rf_we <= 1'b0;
    end else begin
      rf_we <= xfer && (sel_addr != '0);
      if (xfer) begin
        rf_wr_addr <= sel_addr;
        rf_wr_data <= sel_data;
      end
    end
  end

  assign issue_hit = issue_valid && (issue_addr != '0);
  assign clr_same  = rf_we && (rf_wr_addr == issue_addr);

  // Scoreboard next state: clear on commit, set on issue (set wins), flush wipes all
  always_comb begin
    busy_nxt = busy;
    if (rf_we) busy_nxt[rf_wr_addr] = 1'b0;
    if (issue_hit) busy_nxt[issue_addr] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

  // Sticky flag for a second producer issued to a still-pending register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_err <= 1'b0;
    end else if (issue_hit && busy[issue_addr] && !clr_same) begin
      issue_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a cycle-level reference model.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_addr = '0;
  logic        rf_we;
  logic [4:0]  rf_wr_addr;
  logic [63:0] rf_wr_data;
  logic [31:0] busy;
  logic        issue_err;

  regfile_wb_arbiter_if wb_bus ();

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wb          (wb_bus),
    .rf_we       (rf_we),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .busy        (busy),
    .issue_err   (issue_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state after the most recent clock edge
  int          m_ptr = 0;
  bit          m_we = 0;
  bit [4:0]    m_addr = 0;
  bit [63:0]   m_data = 0;
  bit [31:0]   m_busy = 0;
  bit          m_err = 0;

  always @(negedge clk) begin
    logic [2:0]  exp_rdy;
    bit   [31:0] nb;
    int          g;
    int          i;
    if (!rst) begin
      check("rst_ready", wb_bus.src_ready, 0);
      check("rst_we", rf_we, 0);
      check("rst_busy", busy, 0);
      check("rst_err", issue_err, 0);
      m_ptr = 0; m_we = 0; m_addr = 0; m_data = 0; m_busy = 0; m_err = 0;
    end else begin
      exp_rdy = '0;
      g = -1;
      i = 0;
      if (!flush) begin
        for (int k = 0; k < 3; k++) begin
          i = (m_ptr + k) % 3;
          if (g < 0 && wb_bus.src_valid[i]) g = i;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("mdl_ready", wb_bus.src_ready, exp_rdy);
      check("mdl_we", rf_we, m_we);
      if (m_we) begin
        check("mdl_addr", rf_wr_addr, m_addr);
        check("mdl_data", rf_wr_data, m_data);
      end
      check("mdl_busy", busy, m_busy);
      check("mdl_err", issue_err, m_err);
      // advance model across the coming edge
      nb = m_busy;
      if (m_we) nb[m_addr] = 1'b0;
      if (issue_valid && issue_addr != 0) begin
        if (m_busy[issue_addr] && !(m_we && m_addr == issue_addr)) m_err = 1'b1;
        nb[issue_addr] = 1'b1;
      end
      if (flush) nb = '0;
      nb[0] = 1'b0;
      m_busy = nb;
      if (g >= 0) begin
        m_addr = wb_bus.src_addr[g*5 +: 5];
        m_data = wb_bus.src_data[g*64 +: 64];
        m_we   = (m_addr != 0);
        m_ptr  = (g + 1) % 3;
      end else begin
        m_we = 1'b0;
      end
      if (flush) m_ptr = 0;
    end
  end

  // Per-source request queues; head is presented until accepted
  wb_req_t    srcq [3][$];
  logic [2:0] last_rdy = '0;

  task automatic present();
    for (int s = 0; s < 3; s++) begin
      wb_bus.src_valid[s] = (srcq[s].size() > 0);
      if (srcq[s].size() > 0) begin
        wb_bus.src_addr[s*5 +: 5]   = srcq[s][0].addr;
        wb_bus.src_data[s*64 +: 64] = srcq[s][0].data;
      end
    end
  endtask

  task automatic push(input int s, input logic [4:0] a, input logic [63:0] d);
    wb_req_t r;
    r.addr = a;
    r.data = d;
    srcq[s].push_back(r);
  endtask

  // One clock: record the handshake, cross the edge, retire accepted heads
  task automatic tick();
    @(negedge clk);
    #1;
    last_rdy = wb_bus.src_valid & wb_bus.src_ready;
    @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) if (last_rdy[s]) void'(srcq[s].pop_front());
    flush = 1'b0;
    issue_valid = 1'b0;
    issue_addr = '0;
    present();
  endtask

  initial begin
    wb_bus.src_valid = '0;
    wb_bus.src_addr  = '0;
    wb_bus.src_data  = '0;
    // ready stays low in reset even with a request pending
    wb_bus.src_valid = 3'b001;
    #1;
    check("reset_ready_low", wb_bus.src_ready, 0);
    wb_bus.src_valid = '0;
    tick();
    rst = 1'b1;

    // single write
    push(0, 5'd5, 64'hDEAD_BEEF);
    present();
    tick();
    check("single_ready", last_rdy, 3'b001);
    check("single_we", rf_we, 1);
    check("single_addr", rf_wr_addr, 5);
    check("single_data", rf_wr_data, 64'hDEAD_BEEF);
    tick();
    check("single_we_off", rf_we, 0);

    // move pointer back to 0 via a lone source-2 write
    push(2, 5'd4, 64'h44);
    present();
    tick();
    check("src2_ready", last_rdy, 3'b100);
    check("src2_addr", rf_wr_addr, 4);

    // round-robin fairness with all sources competing
    for (int r = 0; r < 2; r++) begin
      push(0, 5'd1, 64'hA0 + 64'(r));
      push(1, 5'd2, 64'hB0 + 64'(r));
      push(2, 5'd3, 64'hC0 + 64'(r));
    end
    present();
    for (int c = 0; c < 6; c++) begin
      logic [2:0] exp_g;
      exp_g = 3'b001 << (c % 3);
      tick();
      check("rr_grant", last_rdy, exp_g);
      check("rr_we", rf_we, 1);
      check("rr_addr", rf_wr_addr, 5'((c % 3) + 1));
    end

    // x0 write is consumed but not committed
    push(1, 5'd0, 64'h1234);
    present();
    tick();
    check("x0_ready", last_rdy, 3'b010);
    check("x0_we", rf_we, 0);
    check("x0_busy", busy, 0);

    // scoreboard set / clear / same-edge set wins
    issue_valid = 1'b1; issue_addr = 5'd7;
    tick();
    check("sb_set7", busy[7], 1);
    push(0, 5'd7, 64'h77);
    present();
    tick();
    check("sb_wr7_we", rf_we, 1);
    check("sb_wr7_addr", rf_wr_addr, 7);
    check("sb_still7", busy[7], 1);
    issue_valid = 1'b1; issue_addr = 5'd7;
    tick();
    check("sb_setwins7", busy[7], 1);
    check("sb_noerr", issue_err, 0);
    push(0, 5'd7, 64'h78);
    present();
    tick();
    tick();
    check("sb_clear7", busy[7], 0);

    // WAW issue raises the sticky error
    issue_valid = 1'b1; issue_addr = 5'd9;
    tick();
    issue_valid = 1'b1; issue_addr = 5'd9;
    tick();
    check("waw_err", issue_err, 1);
    issue_valid = 1'b1; issue_addr = 5'd3;
    tick();
    check("sb_3_9", busy, 32'h0000_0208);

    // flush: in-flight write commits, ready low, busy wiped, pointer reset
    push(1, 5'd12, 64'hC12);
    present();
    tick();
    check("pre_flush_ready", last_rdy, 3'b010);
    check("pre_flush_we", rf_we, 1);
    push(2, 5'd11, 64'hB11);
    present();
    flush = 1'b1;
    tick();
    check("flush_ready", last_rdy, 3'b000);
    check("flush_busy", busy, 0);
    check("flush_we", rf_we, 0);
    push(0, 5'd13, 64'hD13);
    present();
    tick();
    check("post_flush_src0", last_rdy, 3'b001);
    check("post_flush_addr", rf_wr_addr, 13);
    tick();
    check("post_flush_src2", last_rdy, 3'b100);
    check("post_flush_addr2", rf_wr_addr, 11);

    // async reset mid-burst
    push(1, 5'd14, 64'hE14);
    push(1, 5'd15, 64'hE15);
    present();
    issue_valid = 1'b1; issue_addr = 5'd20;
    tick();
    check("burst_we", rf_we, 1);
    check("burst_busy", busy, 32'h0010_0000);
    #2;
    rst = 1'b0;
    #1;
    check("async_we", rf_we, 0);
    check("async_busy", busy, 0);
    check("async_err", issue_err, 0);
    check("async_ready", wb_bus.src_ready, 0);
    for (int s = 0; s < 3; s++) srcq[s].delete();
    present();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    push(0, 5'd16, 64'h16);
    push(2, 5'd17, 64'h17);
    present();
    tick();
    check("after_rst_grant", last_rdy, 3'b001);
    check("after_rst_addr", rf_wr_addr, 16);
    tick();
    check("after_rst_grant2", last_rdy, 3'b100);
    check("after_rst_addr2", rf_wr_addr, 17);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
